hazard_ctrl: RTL and testbench

Stall and forwarding controller for the five-stage MIPS pipeline; the consumer of the per-instruction hazard tuples (r_new, t_new, r_use1/2, t_use1/2) produced in D. It keeps a registered shadow of each in-flight producer in E, M and W, counts its remaining time-to-forwardable down each advance, and from that drives the D-stage stall and the operand forwarding selects.

---
 rtl/hazard_ctrl_pkg.sv | 32 +++
 rtl/hazard_cmp.sv | 40 ++++
 rtl/hazard_ctrl.sv | 83 ++++++++
 tb/tb_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared hazard definitions: record layout, forwarding codes, bubble, saturating decrement.
// Latency: none (types, constants, pure function only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    // Saturating decrement of a 2-bit time-to-forwardable count.
`ifndef HAZARD_SAT_DEC
`define HAZARD_SAT_DEC(x) (((x) == 2'd0) ? 2'd0 : ((x) - 2'd1))
`endif

    localparam int REG_W = 5;
    localparam int CNT_W = 2;

    // Forwarding select codes driven to the D-stage operand muxes.
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // Shadow of one in-flight producer: destination and cycles left until forwardable.
    typedef struct packed {
        logic [REG_W-1:0] r_new;
        logic [CNT_W-1:0] cnt;
    } rec_t;

    localparam rec_t REC_BUBBLE = '{r_new: '0, cnt: '0};

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
        return `HAZARD_SAT_DEC(c);
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Per-operand hazard check: stall request and forwarding select from E/M/W records.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result feeds the top-level stall OR.
module hazard_cmp
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] r_use,
    input  logic [CNT_W-1:0] t_use,
    input  rec_t             e_rec,
    input  rec_t             m_rec,
    input  rec_t             w_rec,
    output logic             stall,
    output logic [1:0]       fwd_sel
);

    logic e_hit;
    logic m_hit;
    logic w_hit;

    // Register 0 is hardwired zero, so it never names a producer.
    assign e_hit = (r_use != '0) && (e_rec.r_new == r_use);
    assign m_hit = (r_use != '0) && (m_rec.r_new == r_use);
    assign w_hit = (r_use != '0) && (w_rec.r_new == r_use);

    // Youngest matching stage wins; a not-yet-ready producer forces the register-file path.
    always_comb begin
        stall   = 1'b0;
        fwd_sel = FWD_RF;
        if (e_hit) begin
            stall   = (e_rec.cnt > t_use);
            fwd_sel = (e_rec.cnt == '0) ? FWD_E : FWD_RF;
        end else if (m_hit) begin
            stall   = (m_rec.cnt > t_use);
            fwd_sel = (m_rec.cnt == '0) ? FWD_M : FWD_RF;
        end else if (w_hit) begin
            fwd_sel = (w_rec.cnt == '0) ? FWD_W : FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forwarding controller for the 5-stage pipeline; optional HAZARD_MD_STALL_EN adds mult/div busy stall.
// Latency: stall/fwd_sel combinational from D tuple; E/M/W records update on the next rising edge.
// Backpressure: stall holds PC and F/D and injects a bubble into E; M and W always advance.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] d_r_new,
    input  logic [CNT_W-1:0] d_t_new,
    input  logic [REG_W-1:0] d_r_use1,
    input  logic [REG_W-1:0] d_r_use2,
    input  logic [CNT_W-1:0] d_t_use1,
    input  logic [CNT_W-1:0] d_t_use2,
`ifdef HAZARD_MD_STALL_EN
    input  logic             d_is_md,
    input  logic             md_busy,
`endif
    output logic             stall,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [REG_W-1:0] e_r_new,
    output logic [REG_W-1:0] m_r_new,
    output logic [REG_W-1:0] w_r_new
);

    rec_t e_rec;
    rec_t m_rec;
    rec_t w_rec;
    logic stall1;
    logic stall2;
    logic md_stall;

    hazard_cmp u_cmp1 (
        .r_use   (d_r_use1),
        .t_use   (d_t_use1),
        .e_rec   (e_rec),
        .m_rec   (m_rec),
        .w_rec   (w_rec),
        .stall   (stall1),
        .fwd_sel (fwd_sel1)
    );

    hazard_cmp u_cmp2 (
        .r_use   (d_r_use2),
        .t_use   (d_t_use2),
        .e_rec   (e_rec),
        .m_rec   (m_rec),
        .w_rec   (w_rec),
        .stall   (stall2),
        .fwd_sel (fwd_sel2)
    );

`ifdef HAZARD_MD_STALL_EN
    assign md_stall = d_is_md & md_busy;
`else
    assign md_stall = 1'b0;
`endif

    assign stall = stall1 | stall2 | md_stall;

    // Records advance every cycle; a stall only replaces the incoming E entry with a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_rec <= REC_BUBBLE;
            m_rec <= REC_BUBBLE;
            w_rec <= REC_BUBBLE;
        end else begin
            if (stall) begin
                e_rec <= REC_BUBBLE;
            end else begin
                e_rec <= '{r_new: d_r_new, cnt: d_t_new};
            end
            m_rec <= '{r_new: e_rec.r_new, cnt: sat_dec(e_rec.cnt)};
            w_rec <= '{r_new: m_rec.r_new, cnt: '0};
        end
    end

    assign e_r_new = e_rec.r_new;
    assign m_r_new = m_rec.r_new;
    assign w_r_new = w_rec.r_new;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] d_r_new;
    logic [1:0] d_t_new;
    logic [4:0] d_r_use1;
    logic [4:0] d_r_use2;
    logic [1:0] d_t_use1;
    logic [1:0] d_t_use2;
`ifdef HAZARD_MD_STALL_EN
    logic       d_is_md;
    logic       md_busy;
`endif
    logic       stall;
    logic [1:0] fwd_sel1;
    logic [1:0] fwd_sel2;
    logic [4:0] e_r_new;
    logic [4:0] m_r_new;
    logic [4:0] w_r_new;

    int passed = 0;
    int total  = 0;

    hazard_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .d_r_new  (d_r_new),
        .d_t_new  (d_t_new),
        .d_r_use1 (d_r_use1),
        .d_r_use2 (d_r_use2),
        .d_t_use1 (d_t_use1),
        .d_t_use2 (d_t_use2),
`ifdef HAZARD_MD_STALL_EN
        .d_is_md  (d_is_md),
        .md_busy  (md_busy),
`endif
        .stall    (stall),
        .fwd_sel1 (fwd_sel1),
        .fwd_sel2 (fwd_sel2),
        .e_r_new  (e_r_new),
        .m_r_new  (m_r_new),
        .w_r_new  (w_r_new)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rn, input logic [1:0] tn,
                         input logic [4:0] u1, input logic [1:0] t1,
                         input logic [4:0] u2, input logic [1:0] t2);
        d_r_new  = rn;
        d_t_new  = tn;
        d_r_use1 = u1;
        d_t_use1 = t1;
        d_r_use2 = u2;
        d_t_use2 = t2;
        #1;
    endtask

    task automatic do_reset();
        set_d(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            total++;
            if (stall !== 1'b0 || fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0 ||
                e_r_new !== 5'd0 || m_r_new !== 5'd0 || w_r_new !== 5'd0)
                $display("FAIL reset_idle cyc%0d: stall=%b sel=%0d/%0d e/m/w=%0d/%0d/%0d required all 0",
                         c, stall, fwd_sel1, fwd_sel2, e_r_new, m_r_new, w_r_new);
            else passed++;
            tick();
        end
    endtask

    task automatic test_fwd_e();
        do_reset();
        set_d(8, 0, 0, 0, 0, 0);
        tick();
        set_d(0, 0, 8, 1, 0, 0);
        total++;
        if (e_r_new !== 5'd8) $display("FAIL fwd_e_rec: e_r_new=%0d required 8", e_r_new);
        else passed++;
        total++;
        if (stall !== 1'b0 || fwd_sel1 !== 2'd1)
            $display("FAIL fwd_e_tuse1: stall=%b sel1=%0d required 0/1", stall, fwd_sel1);
        else passed++;
        set_d(0, 0, 8, 0, 0, 0);
        total++;
        if (stall !== 1'b0 || fwd_sel1 !== 2'd1)
            $display("FAIL fwd_e_tuse0: stall=%b sel1=%0d required 0/1", stall, fwd_sel1);
        else passed++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_d(9, 2, 0, 0, 0, 0);
        tick();
        set_d(0, 0, 9, 1, 0, 0);
        total++;
        if (stall !== 1'b1 || fwd_sel1 !== 2'd0)
            $display("FAIL load_use_stall: stall=%b sel1=%0d required 1/0", stall, fwd_sel1);
        else passed++;
        tick();
        total++;
        if (e_r_new !== 5'd0 || m_r_new !== 5'd9)
            $display("FAIL load_use_bubble: e=%0d m=%0d required 0/9", e_r_new, m_r_new);
        else passed++;
        total++;
        if (stall !== 1'b0 || fwd_sel1 !== 2'd0)
            $display("FAIL load_use_release: stall=%b sel1=%0d required 0/0", stall, fwd_sel1);
        else passed++;
        tick();
        total++;
        if (w_r_new !== 5'd9 || stall !== 1'b0 || fwd_sel1 !== 2'd3)
            $display("FAIL load_use_fwd_w: w=%0d stall=%b sel1=%0d required 9/0/3", w_r_new, stall, fwd_sel1);
        else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        set_d(5, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        set_d(0, 0, 5, 1, 5, 2);
        total++;
        if (stall !== 1'b0 || fwd_sel1 !== 2'd1 || fwd_sel2 !== 2'd1)
            $display("FAIL priority_emw: stall=%b sel=%0d/%0d required 0/1/1", stall, fwd_sel1, fwd_sel2);
        else passed++;
        // Younger not-ready E must hide a ready M match.
        do_reset();
        set_d(6, 1, 0, 0, 0, 0);
        tick();
        tick();
        set_d(0, 0, 6, 1, 6, 0);
        total++;
        if (stall !== 1'b1 || fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0)
            $display("FAIL priority_young_hides: stall=%b sel=%0d/%0d required 1/0/0", stall, fwd_sel1, fwd_sel2);
        else passed++;
        // Record holding r_new=0 with a large count must not match a use of r0.
        do_reset();
        set_d(0, 3, 0, 0, 0, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0);
        total++;
        if (stall !== 1'b0 || fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0)
            $display("FAIL r0_no_match: stall=%b sel=%0d/%0d required 0/0/0", stall, fwd_sel1, fwd_sel2);
        else passed++;
        // Self-hazard: D writes and reads r4, nothing in flight.
        set_d(4, 2, 4, 0, 4, 0);
        total++;
        if (stall !== 1'b0 || fwd_sel1 !== 2'd0)
            $display("FAIL no_self_hazard: stall=%b sel1=%0d required 0/0", stall, fwd_sel1);
        else passed++;
    endtask

    task automatic test_branch();
        do_reset();
        set_d(3, 2, 0, 0, 0, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0);
        tick();
        set_d(0, 0, 3, 0, 0, 0);
        total++;
        if (m_r_new !== 5'd3 || stall !== 1'b1 || fwd_sel1 !== 2'd0)
            $display("FAIL branch_stall: m=%0d stall=%b sel1=%0d required 3/1/0", m_r_new, stall, fwd_sel1);
        else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || e_r_new !== 5'd0 || m_r_new !== 5'd0 || w_r_new !== 5'd0)
            $display("FAIL branch_reset: stall=%b e/m/w=%0d/%0d/%0d required 0/0/0/0",
                     stall, e_r_new, m_r_new, w_r_new);
        else passed++;
    endtask

`ifdef HAZARD_MD_STALL_EN
    task automatic test_md();
        do_reset();
        set_d(4, 0, 0, 0, 0, 0);
        d_is_md = 1'b1;
        md_busy = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (stall !== 1'b1) $display("FAIL md_stall cyc%0d: stall=%b required 1", c, stall);
            else passed++;
            tick();
            total++;
            if (e_r_new !== 5'd0) $display("FAIL md_bubble cyc%0d: e_r_new=%0d required 0", c, e_r_new);
            else passed++;
        end
        md_busy = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0) $display("FAIL md_release: stall=%b required 0", stall);
        else passed++;
        tick();
        total++;
        if (e_r_new !== 5'd4) $display("FAIL md_issue: e_r_new=%0d required 4", e_r_new);
        else passed++;
        d_is_md = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b0;
`ifdef HAZARD_MD_STALL_EN
        d_is_md = 1'b0;
        md_busy = 1'b0;
`endif
        set_d(0, 0, 0, 0, 0, 0);
        test_reset();
        test_fwd_e();
        test_load_use();
        test_priority();
        test_branch();
`ifdef HAZARD_MD_STALL_EN
        test_md();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
